// File: rtl/io_bus_bridge_pkg.sv
// io_bus_bridge_pkg
// Shared encodings for the byte-wide peripheral data bus: bus cycle modes,
// CPU access sizes and the bridge state machine states, plus small helpers
// used to decode a CPU request.
package io_bus_bridge_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10
  } bus_mode_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Number of bytes moved for a given size. The illegal size reports 1 so
  // the end-address arithmetic never underflows; it is rejected anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_HALF: misaligned = addr_lo[0];
      SIZE_WORD: misaligned = |addr_lo;
      default:   misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/io_bus_bridge_load_extend.sv
// load_extend
// Extends the captured load bytes to 32 bits.
//   raw          : captured bytes, byte 0 in [7:0]
//   size         : access size (byte / half / word)
//   is_unsigned  : 1 = zero-extend, 0 = sign-extend
//   ext          : extended result
module load_extend
  import io_bus_bridge_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  logic fill_b;
  logic fill_h;

  always_comb begin
    fill_b = raw[7]  & ~is_unsigned;
    fill_h = raw[15] & ~is_unsigned;
    case (size)
      SIZE_BYTE: ext = {{24{fill_b}}, raw[7:0]};
      SIZE_HALF: ext = {{16{fill_h}}, raw[15:0]};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/io_bus_bridge.sv
// io_bus_bridge
// Bridges single CPU load/store requests onto a byte-wide peripheral bus,
// one bus cycle per byte, little-endian. Requests outside the IO window,
// misaligned or of illegal size complete with an error and no bus cycle.
//   clk, reset (async, active-low)
//   cpu_req/cpu_we/cpu_size/cpu_unsigned/cpu_addr/cpu_wdata : request
//   cpu_rdata/cpu_ready/cpu_error                           : completion
//   data_bus_addr/write/read/mode/select                    : peripheral bus
module io_bus_bridge
  import io_bus_bridge_pkg::*;
#(
  parameter logic [31:0] IO_BASE  = 32'h0000_4000,
  parameter logic [31:0] IO_LIMIT = 32'h0000_40FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_error,
  output logic [31:0] data_bus_addr,
  output logic [7:0]  data_bus_write,
  input  logic [7:0]  data_bus_read,
  output logic [1:0]  data_bus_mode,
  output logic        data_bus_select
);

  state_e      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [1:0]  size_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic        we_q;
  logic        uns_q;
  logic        err_q;

  logic [2:0]  req_bytes;
  logic [32:0] req_end;
  logic        reject;
  logic [1:0]  idx_nxt;
  logic [31:0] ext_data;

  // Request decode; the end address is kept 33 bits wide so an access
  // wrapping past 0xFFFF_FFFF is still seen as beyond the window.
  always_comb begin
    req_bytes = size_bytes(cpu_size);
    req_end   = {1'b0, cpu_addr} + {30'b0, req_bytes} - 33'd1;
    reject    = (cpu_size == SIZE_BAD) | misaligned(cpu_size, cpu_addr[1:0]) |
                (cpu_addr < IO_BASE) | (req_end > {1'b0, IO_LIMIT});
    idx_nxt   = idx_q + 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      addr_q          <= '0;
      wdata_q         <= '0;
      buf_q           <= '0;
      size_q          <= '0;
      idx_q           <= '0;
      last_q          <= '0;
      we_q            <= 1'b0;
      uns_q           <= 1'b0;
      err_q           <= 1'b0;
      cpu_ready       <= 1'b0;
      cpu_error       <= 1'b0;
      data_bus_addr   <= '0;
      data_bus_write  <= '0;
      data_bus_mode   <= BUS_NONE;
      data_bus_select <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cpu_ready <= 1'b0;
          cpu_error <= 1'b0;
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            size_q  <= cpu_size;
            we_q    <= cpu_we;
            uns_q   <= cpu_unsigned;
            idx_q   <= 2'd0;
            last_q  <= 2'(req_bytes - 3'd1);
            buf_q   <= '0;
            if (reject) begin
              err_q     <= 1'b1;
              cpu_ready <= 1'b1;
              cpu_error <= 1'b1;
              state     <= ST_DONE;
            end else begin
              // Byte 0 goes on the bus in the cycle right after acceptance.
              err_q           <= 1'b0;
              data_bus_addr   <= cpu_addr;
              data_bus_write  <= cpu_wdata[7:0];
              data_bus_mode   <= cpu_we ? BUS_WRITE : BUS_READ;
              data_bus_select <= 1'b1;
              state           <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (!we_q) buf_q[{idx_q, 3'b000} +: 8] <= data_bus_read;
          if (idx_q == last_q) begin
            data_bus_addr   <= '0;
            data_bus_write  <= '0;
            data_bus_mode   <= BUS_NONE;
            data_bus_select <= 1'b0;
            cpu_ready       <= 1'b1;
            cpu_error       <= 1'b0;
            state           <= ST_DONE;
          end else begin
            idx_q          <= idx_nxt;
            data_bus_addr  <= addr_q + {30'b0, idx_nxt};
            data_bus_write <= wdata_q[{idx_nxt, 3'b000} +: 8];
          end
        end
        ST_DONE: begin
          cpu_ready <= 1'b0;
          cpu_error <= 1'b0;
          err_q     <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  load_extend u_load_extend (
    .raw         (buf_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext         (ext_data)
  );

  // Load data is only presented during the completion cycle of a good load.
  assign cpu_rdata = (state == ST_DONE && !we_q && !err_q) ? ext_data : 32'h0;

endmodule

// File: doc/io_bus_bridge.md
IO_BUS_BRIDGE -- requirements
Module: io_bus_bridge

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0000_4000, lowest byte address of the IO window.
REQ-002 SHALL have parameter IO_LIMIT, default 32'h0000_40FF, highest byte address of the IO window (inclusive).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req  input  1  CPU access request; sampled only in IDLE.
REQ-006 SHALL have port cpu_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port cpu_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port cpu_unsigned  input  1  1 = zero-extend load data, 0 = sign-extend.
REQ-009 SHALL have port cpu_addr  input  32  byte address.
REQ-010 SHALL have port cpu_wdata  input  32  store data, little-endian.
REQ-011 SHALL have port cpu_rdata  output  32  load result, valid while cpu_ready=1.
REQ-012 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port cpu_error  output  1  qualifies cpu_ready; access rejected.
REQ-014 SHALL have port data_bus_addr  output  32  peripheral byte address.
REQ-015 SHALL have port data_bus_write  output  8  peripheral write byte.
REQ-016 SHALL have port data_bus_read  input  8  peripheral read byte, combinational from the peripheral.
REQ-017 SHALL have port data_bus_mode  output  2  00 nothing, 01 read, 10 write.
REQ-018 SHALL have port data_bus_select  output  1  high during every peripheral byte cycle.

Function
REQ-019 SHALL implement the states IDLE, XFER and DONE.
REQ-020 In IDLE with cpu_req=1, SHALL latch addr, wdata, size, we and unsigned, and SHALL set byte count N = 1/2/4 for size 00/01/10.
REQ-021 SHALL reject a request (go to DONE with error) if size=11, half addr[0]!=0, word addr[1:0]!=0, or addr<IO_BASE, or addr+N-1>IO_LIMIT.
REQ-022 A rejected request SHALL produce no cycle with data_bus_mode!=00.
REQ-023 For an accepted request, SHALL enter XFER and spend exactly one cycle per byte i=0..N-1, driving data_bus_addr=addr+i, data_bus_select=1, data_bus_mode=10 (store) or 01 (load), and data_bus_write=wdata[8i+7:8i].
REQ-024 On loads, SHALL capture data_bus_read into byte i of an internal buffer at the end of each XFER cycle.
REQ-025 After byte N-1, SHALL enter DONE for exactly one cycle with cpu_ready=1 and cpu_error as determined in REQ-021, then return to IDLE.
REQ-026 Latency: an accepted request SHALL reach cpu_ready N+1 cycles after the accepting edge; a rejected request SHALL reach it 1 cycle after.
REQ-027 In DONE on a load, cpu_rdata SHALL be the N captured bytes extended to 32 bits per cpu_unsigned; on a store or on error, cpu_rdata SHALL be 0.
REQ-028 Outside XFER, data_bus_mode SHALL be 00, data_bus_select 0, data_bus_write 0 and data_bus_addr 0.
REQ-029 cpu_req SHALL be ignored in XFER and DONE; a new request SHALL be accepted only in IDLE, so back-to-back requests are separated by the DONE cycle.
REQ-030 Input changes during XFER SHALL NOT affect the transfer in progress.

Reset
REQ-031 On reset low, SHALL go to IDLE immediately, clear latched fields and the buffer, and drive cpu_ready=0, cpu_error=0, cpu_rdata=0, data_bus_mode=00, data_bus_select=0, data_bus_addr=0, data_bus_write=0.
REQ-032 A transfer interrupted by reset SHALL be abandoned without cpu_ready; bytes already written stay written.

Structure
REQ-033 The bus mode encodings (00/01/10), size encodings and state encodings SHALL live in a shared package used by all data-bus peripherals.
REQ-034 The byte extension of REQ-027 SHALL be a sub-module named load_extend; the rest stays flat.

Verification
REQ-035 Byte store of 0xA5 to 0x40F0 -> one cycle with mode=10, addr=0x40F0, write=0xA5; cpu_ready next cycle; a downstream LED register shows 0xA5.
REQ-036 Word store of 0x11223344 to 0x40F0 -> 4 cycles with addr F0..F3 and data 44,33,22,11; cpu_ready at cycle 5, error=0.
REQ-037 Byte load from 0x40F0 with read data 0x80 -> cpu_rdata=0xFFFFFF80 when signed, 0x00000080 when unsigned.
REQ-038 Half store to 0x40F1, then a word load at 0x3FFC -> each gives cpu_ready+cpu_error 1 cycle after request, mode stays 00 throughout.
REQ-039 Reset asserted after the 2nd byte of a word store -> mode=00 immediately, no cpu_ready; after release, a byte store completes normally.
